// File: rtl/crc_pkg.sv
// crc_pkg: shared types, CAN CRC-15 constants and the single-bit CRC update used by
// crc_step / crc_engine.
//   crc_state_t   : engine FSM state (StIdle, StRun, StDone)
//   crc_next_bit  : one Galois MSB-first LFSR step for a register of up to 32 bits
package crc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } crc_state_t;

    // CAN: x^15 + x^14 + x^10 + x^8 + x^7 + x^4 + x^3 + 1, x^15 implicit
    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
    localparam logic [14:0] CAN_CRC15_INIT = 15'h0000;

    // One bit of Galois MSB-first update. Register and polynomial are carried
    // right-aligned in 32 bits; bits at and above 'width' are cleared on return.
    function automatic logic [31:0] crc_next_bit(
        input logic [31:0] crc_reg,
        input logic        d,
        input logic [31:0] poly,
        input int unsigned width
    );
        logic        fb;
        logic [31:0] nxt;
        logic [31:0] mask;
        fb   = crc_reg[5'(width - 1)] ^ d;
        nxt  = {crc_reg[30:0], 1'b0} ^ (fb ? poly : 32'd0);
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/crc_step.sv
// crc_step: purely combinational BITS-deep unroll of crc_next_bit.
//   crc_in  [WIDTH] : current CRC register
//   data    [BITS]  : beat, data[BITS-1] is consumed first
//   crc_out [WIDTH] : register after all BITS bits have been shifted in
module crc_step import crc_pkg::*; #(
    parameter int unsigned       WIDTH = 15,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(CAN_CRC15_POLY),
    parameter int unsigned       BITS  = 1
) (
    input  logic [WIDTH-1:0] crc_in,
    input  logic [BITS-1:0]  data,
    output logic [WIDTH-1:0] crc_out
);

    logic [WIDTH-1:0] acc;
    logic [BITS-1:0]  sh;

    always_comb begin
        acc = crc_in;
        sh  = data;
        for (int unsigned i = 0; i < BITS; i++) begin
            acc = WIDTH'(crc_next_bit(32'(acc), sh[BITS-1], 32'(POLY), WIDTH));
            // Left shift keeps the next bit to process at the MSB.
            sh  = sh << 1;
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_engine.sv
// crc_engine: handshaked CRC generator/checker, BITS bits per beat, MSB-first.
//   clk, rst (async, active-high)
//   start                       : begin a calculation (sampled in IDLE and DONE)
//   in_valid, in_data, in_last  : beat input; in_ready high only in RUN
//   busy                        : high in RUN and DONE
//   crc                         : register ^ XOR_OUT, held from DONE until next start
//   crc_valid                   : one-cycle strobe in DONE
//   crc_ok                      : with crc_valid, raw register is zero
// All outputs derive from registered state only; no input-to-output path.
module crc_engine import crc_pkg::*; #(
    parameter int unsigned      WIDTH   = 15,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(CAN_CRC15_POLY),
    parameter logic [WIDTH-1:0] INIT    = WIDTH'(CAN_CRC15_INIT),
    parameter logic [WIDTH-1:0] XOR_OUT = '0,
    parameter int unsigned      BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [BITS-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             busy,
    output logic [WIDTH-1:0] crc,
    output logic             crc_valid,
    output logic             crc_ok
);

    crc_state_t       state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [WIDTH-1:0] step_out;

    crc_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .BITS  (BITS)
    ) u_step (
        .crc_in  (reg_q),
        .data    (in_data),
        .crc_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    reg_d   = INIT;
                end
            end
            StRun: begin
                // in_ready is implied by being in RUN; start is ignored here.
                if (in_valid) begin
                    reg_d = step_out;
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    reg_d   = INIT;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                reg_d   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            reg_q   <= INIT;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
        end
    end

    assign in_ready  = (state_q == StRun);
    assign busy      = (state_q != StIdle);
    assign crc_valid = (state_q == StDone);
    assign crc_ok    = (state_q == StDone) && (reg_q == '0);
    assign crc       = reg_q ^ XOR_OUT;

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised, handshaked CRC generator/checker; successor to the single-bit CAN CRC-15 LFSR. Consumes `BITS` bits per accepted beat, MSB-first, for any polynomial up to 32 bits. Raises a one-cycle completion strobe and a zero-remainder check flag. Sits between the CAN bit-destuffer and the frame FSM: it generates CRC on TX and checks CRC on RX by feeding the received CRC field through the engine.

## Interface
- `WIDTH`, 15: CRC width, 1..32.
- `POLY`, 15'h4599: generator polynomial, implicit x^WIDTH term omitted (CAN: x^15+x^14+x^10+x^8+x^7+x^4+x^3+1).
- `INIT`, 0: register value loaded on `start` and on reset.
- `XOR_OUT`, 0: XOR applied to the register to form `crc`.
- `BITS`, 1: bits per beat, 1..8; `in_data[BITS-1]` is processed first.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: begin a new calculation; sampled only in IDLE and DONE.
- `in_valid` in 1: beat present on `in_data`.
- `in_data` in BITS: serial data, MSB-first within the beat.
- `in_last` in 1: qualifies the final beat of the message.
- `in_ready` out 1: engine accepts beats; high only in RUN.
- `busy` out 1: high in RUN and DONE.
- `crc` out WIDTH: register XOR `XOR_OUT`; held stable from DONE until the next `start`.
- `crc_valid` out 1: one-cycle strobe in DONE.
- `crc_ok` out 1: meaningful with `crc_valid`; 1 when the raw register (before `XOR_OUT`) equals 0.

## Operation
- Per-bit update (Galois, MSB-first): `fb = reg[WIDTH-1] ^ d`; `reg = {reg[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)`. This is applied `BITS` times per accepted beat, unrolled combinationally.
- A beat is accepted when `in_valid & in_ready`.
- FSM:
  - IDLE: `start` loads `INIT` and moves to RUN.
  - RUN: each accepted beat updates the register. An accepted beat with `in_last` moves to DONE. `start` is ignored in RUN.
  - DONE: lasts exactly one cycle with `crc_valid=1`. The next state is RUN if `start` is high (the register reloads `INIT`), otherwise IDLE.
- Checker use: feed the message followed by the received CRC field (with `XOR_OUT=0`). `crc_ok=1` indicates no error.
- `in_valid` low in RUN: the register holds. There is no timeout.
- `in_last` without `in_valid`: ignored.
- Message length is arbitrary, down to one beat. Zero-length messages are not supported.
- Reset (any time, including mid-message):
  - State returns to IDLE and the register loads `INIT`.
  - `in_ready`, `busy`, `crc_valid` and `crc_ok` go to 0, and `crc` goes to `INIT^XOR_OUT`.
  - Any partial message is discarded.

## Timing
- `start` at cycle t: `in_ready=1` from t+1.
- Last beat accepted at cycle n: `crc_valid`, `crc_ok` and the final `crc` are visible at n+1. Latency is 1 cycle.
- Throughput is one beat per cycle (`BITS` bits/clk). Back-to-back messages lose 1 cycle: a `start` during DONE gives RUN at n+2.
- All outputs are registered or decoded from the state register only. There is no input-to-output combinational path.

## Structure
- The package `crc_pkg` holds:
  - the state enum `crc_state_t` (IDLE, RUN, DONE);
  - `CAN_CRC15_POLY = 15'h4599` and `CAN_CRC15_INIT = 0`;
  - the function `crc_next_bit(reg, d, poly)`.
- Sub-module `crc_step`: purely combinational `BITS`-deep unroll of `crc_next_bit`. It is instantiated once; the FSM and register live in `crc_engine`.

## Test plan
- CRC-15/CAN, BITS=8: `start`, then the ASCII bytes "123456789" back-to-back with `in_last` on "9" -> `crc_valid` one cycle later, `crc=15'h059E`.
- Same message with BITS=1 (72 beats) and random `in_valid` gaps -> `crc=15'h059E`, with `crc_valid` exactly one cycle after the last accepted beat.
- Checker: the 72 message bits followed by the 15 bits of 0x059E, BITS=1 -> `crc=0`, `crc_ok=1`. Flip one message bit -> `crc_ok=0`.
- CRC-8 (WIDTH=8, POLY=8'h07, INIT=0), BITS=8, "123456789" -> `crc=8'hF4`.
- Assert `rst` after 4 bytes, release, then send the full message -> `crc=15'h059E`. Verify that all outputs hold their reset values while `rst` is high.
- `start` held high through DONE, then two messages back-to-back -> two `crc_valid` pulses, each with the correct CRC. `start` pulsed during RUN has no effect on the result.
